mem_arbiter: RTL and testbench

- Shares the single memory port between the CPU control path and a DMA requester.
- Both requesters use the CPU's memory handshake: execute pulse, mem_ready, data_ready.
- Each side gets a one-entry request slot. Arbitration is fixed priority to the CPU, with a starvation guard for the DMA.
- Sits between ctrl-side/DMA memory interfaces and the memory controller.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_req_slot.sv | 62 ++++++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner codes and the
// winner-selection rule.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_BUSY  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_e;

    // CPU has priority unless it has used up its streak while DMA waits.
    function automatic logic pick_cpu(input logic cpu_v, input logic dma_v,
                                      input logic streak_full);
        return cpu_v && (!dma_v || !streak_full);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU-side, DMA-side and memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view, the master modport is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) ();
    logic                  I_cpu_execute;
    logic                  I_cpu_we;
    logic [ADDR_WIDTH-1:0] I_cpu_addr;
    logic [DATA_WIDTH-1:0] I_cpu_data;
    logic                  O_cpu_mem_ready;
    logic                  O_cpu_data_ready;
    logic [DATA_WIDTH-1:0] O_cpu_data;

    logic                  I_dma_execute;
    logic                  I_dma_we;
    logic [ADDR_WIDTH-1:0] I_dma_addr;
    logic [DATA_WIDTH-1:0] I_dma_data;
    logic                  O_dma_mem_ready;
    logic                  O_dma_data_ready;
    logic [DATA_WIDTH-1:0] O_dma_data;

    logic                  O_mem_execute;
    logic                  O_mem_we;
    logic [ADDR_WIDTH-1:0] O_mem_addr;
    logic [DATA_WIDTH-1:0] O_mem_data;
    logic                  I_mem_ready;
    logic                  I_mem_data_ready;
    logic [DATA_WIDTH-1:0] I_mem_data;

    logic [1:0]            O_owner;

    modport slave (
        input  I_cpu_execute, I_cpu_we, I_cpu_addr, I_cpu_data,
        output O_cpu_mem_ready, O_cpu_data_ready, O_cpu_data,
        input  I_dma_execute, I_dma_we, I_dma_addr, I_dma_data,
        output O_dma_mem_ready, O_dma_data_ready, O_dma_data,
        output O_mem_execute, O_mem_we, O_mem_addr, O_mem_data,
        input  I_mem_ready, I_mem_data_ready, I_mem_data,
        output O_owner
    );

    modport master (
        output I_cpu_execute, I_cpu_we, I_cpu_addr, I_cpu_data,
        input  O_cpu_mem_ready, O_cpu_data_ready, O_cpu_data,
        output I_dma_execute, I_dma_we, I_dma_addr, I_dma_data,
        input  O_dma_mem_ready, O_dma_data_ready, O_dma_data,
        input  O_mem_execute, O_mem_we, O_mem_addr, O_mem_data,
        output I_mem_ready, I_mem_data_ready, I_mem_data,
        input  O_owner
    );
endinterface

// File: rtl/mem_req_slot.sv
// One-entry request slot: captures a request on an execute pulse while empty,
// holds it until the arbiter clears it on completion.
module mem_req_slot
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  execute_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  clear_i,
    output logic                  valid_o,
    output logic                  mem_ready_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    logic                  valid_q, valid_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // A pulse against a full slot is dropped; the held request is untouched.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (execute_i && !valid_q) begin
            valid_d = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o     = valid_q;
    assign mem_ready_o = !valid_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between CPU and DMA requesters: fixed CPU priority
// with a streak limit that guarantees a waiting DMA request eventually wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_CPU_STREAK = 4
) (
    input  logic          I_clk,
    input  logic          I_reset,
    mem_arbiter_if.slave  bus
);
    localparam int SW = (MAX_CPU_STREAK < 1) ? 1 : $clog2(MAX_CPU_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CPU_STREAK);

    logic                  cpu_valid, cpu_clear, cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  dma_valid, dma_clear, dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
    logic                  cpu_dr_q, cpu_dr_d;
    logic                  dma_dr_q, dma_dr_d;
    logic                  cpu_wins, done;

    mem_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_cpu_slot (
        .clk_i       (I_clk),
        .reset_i     (I_reset),
        .execute_i   (bus.I_cpu_execute),
        .we_i        (bus.I_cpu_we),
        .addr_i      (bus.I_cpu_addr),
        .data_i      (bus.I_cpu_data),
        .clear_i     (cpu_clear),
        .valid_o     (cpu_valid),
        .mem_ready_o (bus.O_cpu_mem_ready),
        .we_o        (cpu_we),
        .addr_o      (cpu_addr),
        .data_o      (cpu_wdata)
    );

    mem_req_slot #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_dma_slot (
        .clk_i       (I_clk),
        .reset_i     (I_reset),
        .execute_i   (bus.I_dma_execute),
        .we_i        (bus.I_dma_we),
        .addr_i      (bus.I_dma_addr),
        .data_i      (bus.I_dma_data),
        .clear_i     (dma_clear),
        .valid_o     (dma_valid),
        .mem_ready_o (bus.O_dma_mem_ready),
        .we_o        (dma_we),
        .addr_o      (dma_addr),
        .data_o      (dma_wdata)
    );

    assign cpu_wins = pick_cpu(cpu_valid, dma_valid, streak_q == STREAK_MAX);
    assign done     = mem_we_q ? bus.I_mem_ready : bus.I_mem_data_ready;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_dr_d    = 1'b0;
        dma_dr_d    = 1'b0;
        cpu_clear   = 1'b0;
        dma_clear   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.I_mem_ready && (cpu_valid || dma_valid)) begin
                    state_d = ST_ISSUE;
                    if (cpu_wins) begin
                        owner_d    = OWN_CPU;
                        mem_we_d   = cpu_we;
                        mem_addr_d = cpu_addr;
                        mem_data_d = cpu_wdata;
                        // Streak only grows while DMA is actually being held off.
                        if (!dma_valid)                streak_d = '0;
                        else if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
                    end else begin
                        owner_d    = OWN_DMA;
                        mem_we_d   = dma_we;
                        mem_addr_d = dma_addr;
                        mem_data_d = dma_wdata;
                        streak_d   = '0;
                    end
                end
            end
            ST_ISSUE: state_d = ST_GAP;
            ST_GAP:   state_d = ST_BUSY;
            ST_BUSY: begin
                if (done) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_CPU) begin
                        cpu_clear = 1'b1;
                        if (!mem_we_q) begin
                            cpu_rdata_d = bus.I_mem_data;
                            cpu_dr_d    = 1'b1;
                        end
                    end else begin
                        dma_clear = 1'b1;
                        if (!mem_we_q) begin
                            dma_rdata_d = bus.I_mem_data;
                            dma_dr_d    = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            streak_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_dr_q    <= 1'b0;
            dma_dr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_dr_q    <= cpu_dr_d;
            dma_dr_q    <= dma_dr_d;
        end
    end

    assign bus.O_mem_execute    = (state_q == ST_ISSUE);
    assign bus.O_mem_we         = mem_we_q;
    assign bus.O_mem_addr       = mem_addr_q;
    assign bus.O_mem_data       = mem_data_q;
    assign bus.O_owner          = owner_q;
    assign bus.O_cpu_data       = cpu_rdata_q;
    assign bus.O_cpu_data_ready = cpu_dr_q;
    assign bus.O_dma_data       = dma_rdata_q;
    assign bus.O_dma_data_ready = dma_dr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: the bench plays CPU, DMA and
// the memory controller, one task per scenario.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_CPU_STREAK(4)) dut (
        .I_clk   (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    // Protocol rule: never pulse execute into a full slot.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.I_cpu_execute && !bus.O_cpu_mem_ready)) else $error("cpu execute into full slot");
            assert (!(bus.I_dma_execute && !bus.O_dma_mem_ready)) else $error("dma execute into full slot");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.I_cpu_execute = 0; bus.I_cpu_we = 0; bus.I_cpu_addr = '0; bus.I_cpu_data = '0;
        bus.I_dma_execute = 0; bus.I_dma_we = 0; bus.I_dma_addr = '0; bus.I_dma_data = '0;
        bus.I_mem_ready = 1; bus.I_mem_data_ready = 0; bus.I_mem_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called in the ISSUE cycle; returns in the cycle after completion.
    task automatic serve_read(input logic [15:0] d, input int extra, input logic hold);
        tick();
        bus.I_mem_ready = 0;
        tick();
        repeat (extra) tick();
        bus.I_mem_data_ready = 1; bus.I_mem_data = d; bus.I_mem_ready = !hold;
        tick();
        bus.I_mem_data_ready = 0; bus.I_mem_data = '0;
    endtask

    task automatic wait_issue(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.O_mem_execute) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.O_cpu_mem_ready !== 1'b1) $display("FAIL rst_cpu_mem_ready: got %b want 1", bus.O_cpu_mem_ready); else passes++;
        checks++; if (bus.O_dma_mem_ready !== 1'b1) $display("FAIL rst_dma_mem_ready: got %b want 1", bus.O_dma_mem_ready); else passes++;
        checks++; if (bus.O_mem_execute !== 1'b0) $display("FAIL rst_mem_execute: got %b want 0", bus.O_mem_execute); else passes++;
        checks++; if (bus.O_owner !== 2'b00) $display("FAIL rst_owner: got %b want 00", bus.O_owner); else passes++;
        checks++; if ({bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data} !== 33'h0) $display("FAIL rst_mem_bus: got %h want 0", {bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data}); else passes++;
        checks++; if ({bus.O_cpu_data_ready, bus.O_cpu_data, bus.O_dma_data_ready, bus.O_dma_data} !== 34'h0) $display("FAIL rst_resp: got %h want 0", {bus.O_cpu_data_ready, bus.O_cpu_data, bus.O_dma_data_ready, bus.O_dma_data}); else passes++;
        checks++; if (dut.state_q !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); else passes++;
        checks++; if (dut.streak_q !== 3'd0) $display("FAIL rst_streak: got %0d want 0", dut.streak_q); else passes++;
    endtask

    task automatic test_cpu_read();
        bus.I_cpu_execute = 1; bus.I_cpu_we = 0; bus.I_cpu_addr = 16'h0040;
        tick();
        bus.I_cpu_execute = 0;
        checks++; if (bus.O_cpu_mem_ready !== 1'b0) $display("FAIL rd_slot_full: got %b want 0", bus.O_cpu_mem_ready); else passes++;
        checks++; if (bus.O_mem_execute !== 1'b0) $display("FAIL rd_no_bypass: got %b want 0", bus.O_mem_execute); else passes++;
        tick();
        checks++; if (bus.O_mem_execute !== 1'b1) $display("FAIL rd_execute: got %b want 1", bus.O_mem_execute); else passes++;
        checks++; if (bus.O_owner !== 2'b01) $display("FAIL rd_owner: got %b want 01", bus.O_owner); else passes++;
        checks++; if ({bus.O_mem_we, bus.O_mem_addr} !== {1'b0, 16'h0040}) $display("FAIL rd_mem_req: got %h want %h", {bus.O_mem_we, bus.O_mem_addr}, {1'b0, 16'h0040}); else passes++;
        serve_read(16'hBEEF, 1, 1'b0);
        checks++; if (bus.O_cpu_data_ready !== 1'b1) $display("FAIL rd_data_ready: got %b want 1", bus.O_cpu_data_ready); else passes++;
        checks++; if (bus.O_cpu_data !== 16'hBEEF) $display("FAIL rd_data: got %h want beef", bus.O_cpu_data); else passes++;
        checks++; if (bus.O_cpu_mem_ready !== 1'b1) $display("FAIL rd_mem_ready_back: got %b want 1", bus.O_cpu_mem_ready); else passes++;
        checks++; if (bus.O_dma_data_ready !== 1'b0) $display("FAIL rd_dma_quiet: got %b want 0", bus.O_dma_data_ready); else passes++;
        tick();
        checks++; if ({bus.O_cpu_data_ready, bus.O_cpu_data} !== {1'b0, 16'hBEEF}) $display("FAIL rd_pulse_hold: got %h want %h", {bus.O_cpu_data_ready, bus.O_cpu_data}, {1'b0, 16'hBEEF}); else passes++;
    endtask

    task automatic test_dma_write();
        bus.I_dma_execute = 1; bus.I_dma_we = 1; bus.I_dma_addr = 16'h1000; bus.I_dma_data = 16'h1234;
        tick();
        bus.I_dma_execute = 0; bus.I_dma_we = 0; bus.I_dma_addr = '0; bus.I_dma_data = '0;
        tick();
        checks++; if ({bus.O_mem_execute, bus.O_owner} !== 3'b110) $display("FAIL wr_issue: got %b want 110", {bus.O_mem_execute, bus.O_owner}); else passes++;
        checks++; if ({bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data} !== {1'b1, 16'h1000, 16'h1234}) $display("FAIL wr_req: got %h want %h", {bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data}, {1'b1, 16'h1000, 16'h1234}); else passes++;
        tick();
        bus.I_mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bus.O_mem_execute, bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data, bus.O_dma_mem_ready, bus.O_dma_data_ready} !== {1'b0, 1'b1, 16'h1000, 16'h1234, 1'b0, 1'b0})
                $display("FAIL wr_hold%0d: got %h want %h", i, {bus.O_mem_execute, bus.O_mem_we, bus.O_mem_addr, bus.O_mem_data, bus.O_dma_mem_ready, bus.O_dma_data_ready}, {1'b0, 1'b1, 16'h1000, 16'h1234, 1'b0, 1'b0});
            else passes++;
            tick();
        end
        bus.I_mem_ready = 1;
        checks++; if (bus.O_dma_mem_ready !== 1'b0) $display("FAIL wr_ready_early: got %b want 0", bus.O_dma_mem_ready); else passes++;
        tick();
        checks++; if (bus.O_dma_mem_ready !== 1'b1) $display("FAIL wr_ready_back: got %b want 1", bus.O_dma_mem_ready); else passes++;
        checks++; if (bus.O_dma_data_ready !== 1'b0) $display("FAIL wr_no_data_ready: got %b want 0", bus.O_dma_data_ready); else passes++;
    endtask

    task automatic test_simultaneous();
        bus.I_cpu_execute = 1; bus.I_cpu_we = 0; bus.I_cpu_addr = 16'h0100;
        bus.I_dma_execute = 1; bus.I_dma_we = 0; bus.I_dma_addr = 16'h0200;
        tick();
        bus.I_cpu_execute = 0; bus.I_dma_execute = 0;
        tick();
        checks++; if ({bus.O_mem_execute, bus.O_owner, bus.O_mem_addr} !== {1'b1, 2'b01, 16'h0100}) $display("FAIL sim_cpu_first: got %h want %h", {bus.O_mem_execute, bus.O_owner, bus.O_mem_addr}, {1'b1, 2'b01, 16'h0100}); else passes++;
        serve_read(16'h1111, 0, 1'b0);
        checks++; if ({bus.O_cpu_data_ready, bus.O_cpu_data} !== {1'b1, 16'h1111}) $display("FAIL sim_cpu_data: got %h want %h", {bus.O_cpu_data_ready, bus.O_cpu_data}, {1'b1, 16'h1111}); else passes++;
        checks++; if ({bus.O_mem_execute, bus.O_dma_mem_ready} !== 2'b00) $display("FAIL sim_dma_waiting: got %b want 00", {bus.O_mem_execute, bus.O_dma_mem_ready}); else passes++;
        tick();
        checks++; if ({bus.O_mem_execute, bus.O_owner, bus.O_mem_addr} !== {1'b1, 2'b10, 16'h0200}) $display("FAIL sim_dma_next: got %h want %h", {bus.O_mem_execute, bus.O_owner, bus.O_mem_addr}, {1'b1, 2'b10, 16'h0200}); else passes++;
        serve_read(16'h2222, 0, 1'b0);
        checks++; if ({bus.O_dma_data_ready, bus.O_dma_data, bus.O_cpu_data} !== {1'b1, 16'h2222, 16'h1111}) $display("FAIL sim_dma_data: got %h want %h", {bus.O_dma_data_ready, bus.O_dma_data, bus.O_cpu_data}, {1'b1, 16'h2222, 16'h1111}); else passes++;
    endtask

    task automatic test_streak();
        logic [1:0]  exp_own [6];
        logic [2:0]  exp_str [6];
        logic        ok;
        logic [15:0] d;
        exp_own[0] = 2'b01; exp_own[1] = 2'b01; exp_own[2] = 2'b01;
        exp_own[3] = 2'b01; exp_own[4] = 2'b10; exp_own[5] = 2'b01;
        exp_str[0] = 3'd1; exp_str[1] = 3'd2; exp_str[2] = 3'd3;
        exp_str[3] = 3'd4; exp_str[4] = 3'd0; exp_str[5] = 3'd0;
        do_reset();
        bus.I_cpu_execute = 1; bus.I_cpu_we = 0; bus.I_cpu_addr = 16'h0500;
        bus.I_dma_execute = 1; bus.I_dma_we = 0; bus.I_dma_addr = 16'h0600;
        tick();
        bus.I_cpu_execute = 0; bus.I_dma_execute = 0;
        for (int k = 0; k < 6; k++) begin
            d = 16'(16'hA000 + k);
            wait_issue(ok);
            checks++; if (ok !== 1'b1) $display("FAIL str_issue%0d: got no issue, want issue within 10 cycles", k); else passes++;
            checks++; if (bus.O_owner !== exp_own[k]) $display("FAIL str_owner%0d: got %b want %b", k, bus.O_owner, exp_own[k]); else passes++;
            checks++; if (dut.streak_q !== exp_str[k]) $display("FAIL str_count%0d: got %0d want %0d", k, dut.streak_q, exp_str[k]); else passes++;
            serve_read(d, 0, 1'b1);
            if (exp_own[k] == 2'b01) begin
                checks++; if ({bus.O_cpu_data_ready, bus.O_cpu_data, bus.O_dma_data_ready} !== {1'b1, d, 1'b0}) $display("FAIL str_cpu_resp%0d: got %h want %h", k, {bus.O_cpu_data_ready, bus.O_cpu_data, bus.O_dma_data_ready}, {1'b1, d, 1'b0}); else passes++;
            end else begin
                checks++; if ({bus.O_dma_data_ready, bus.O_dma_data, bus.O_cpu_data_ready} !== {1'b1, d, 1'b0}) $display("FAIL str_dma_resp%0d: got %h want %h", k, {bus.O_dma_data_ready, bus.O_dma_data, bus.O_cpu_data_ready}, {1'b1, d, 1'b0}); else passes++;
            end
            if (k < 4) begin
                bus.I_cpu_execute = 1; bus.I_cpu_addr = 16'(16'h0500 + k + 1);
                tick();
                bus.I_cpu_execute = 0;
            end
            bus.I_mem_ready = 1;
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        bus.I_mem_ready = 0;
        bus.I_cpu_execute = 1; bus.I_cpu_we = 1; bus.I_cpu_addr = 16'h0700; bus.I_cpu_data = 16'h7777;
        bus.I_dma_execute = 1; bus.I_dma_we = 1; bus.I_dma_addr = 16'h0800; bus.I_dma_data = 16'h8888;
        tick();
        bus.I_cpu_execute = 0; bus.I_dma_execute = 0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.O_mem_execute !== 1'b0) $display("FAIL stall_no_issue%0d: got %b want 0", i, bus.O_mem_execute); else passes++;
            tick();
        end
        bus.I_mem_ready = 1;
        tick();
        checks++; if ({bus.O_mem_execute, bus.O_owner, bus.O_mem_addr, bus.O_mem_data} !== {1'b1, 2'b01, 16'h0700, 16'h7777}) $display("FAIL stall_cpu_wins: got %h want %h", {bus.O_mem_execute, bus.O_owner, bus.O_mem_addr, bus.O_mem_data}, {1'b1, 2'b01, 16'h0700, 16'h7777}); else passes++;
    endtask

    task automatic test_reset_busy();
        logic ok;
        do_reset();
        bus.I_dma_execute = 1; bus.I_dma_we = 0; bus.I_dma_addr = 16'h0300;
        tick();
        bus.I_dma_execute = 0;
        wait_issue(ok);
        checks++; if ({ok, bus.O_owner} !== 3'b110) $display("FAIL rb_issue: got %b want 110", {ok, bus.O_owner}); else passes++;
        tick();
        bus.I_mem_ready = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (dut.state_q !== ST_IDLE) $display("FAIL rb_state: got %0d want %0d", dut.state_q, ST_IDLE); else passes++;
        checks++; if ({bus.O_cpu_mem_ready, bus.O_dma_mem_ready, bus.O_owner, bus.O_mem_execute} !== 5'b11000) $display("FAIL rb_outputs: got %b want 11000", {bus.O_cpu_mem_ready, bus.O_dma_mem_ready, bus.O_owner, bus.O_mem_execute}); else passes++;
        bus.I_mem_data_ready = 1; bus.I_mem_data = 16'hDEAD; bus.I_mem_ready = 1;
        tick();
        bus.I_mem_data_ready = 0; bus.I_mem_data = '0;
        checks++; if ({bus.O_dma_data_ready, bus.O_dma_data} !== 17'h0) $display("FAIL rb_late_data: got %h want 0", {bus.O_dma_data_ready, bus.O_dma_data}); else passes++;
        tick();
        checks++; if ({bus.O_mem_execute, bus.O_dma_data_ready, bus.O_cpu_data_ready} !== 3'b000) $display("FAIL rb_quiet: got %b want 000", {bus.O_mem_execute, bus.O_dma_data_ready, bus.O_cpu_data_ready}); else passes++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_simultaneous();
        test_streak();
        test_mem_stall();
        test_reset_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
